// File: rtl/fwd_hazard_pkg.sv
// Shared types and select encodings for the forwarding/hazard controller.
package fwd_hazard_pkg;
  localparam int REG_W      = 5;
  localparam int SB_CNT_W   = 8;
  localparam int FWD_SEL_RF = 0;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic                valid;
    reg_idx_t            rd;
    logic [SB_CNT_W-1:0] cnt;
  } sb_entry_t;

  // The MC result select sits just past the oldest forwarding stage.
  function automatic int fwd_sel_mc(input int num_fwd);
    return num_fwd + 1;
  endfunction
endpackage

// File: rtl/fwd_hazard_unit_scoreboard.sv
// Scoreboard of in-flight fixed-latency MC ops: allocation, countdown,
// WAW invalidation and the match/occupancy queries used by the hazard logic.
module fwd_scoreboard
  import fwd_hazard_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int SB_DEPTH = 2,
  parameter int MC_LAT   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_pipe_en,
  input  logic                     i_ex_wr,
  input  logic                     i_ex_alloc_req,
  input  reg_idx_t                 i_ex_rd,
  input  reg_idx_t [NUM_SRC-1:0]   i_ex_rs,
  input  reg_idx_t [NUM_SRC-1:0]   i_id_rs,
  output logic     [NUM_SRC-1:0]   o_ex_mc_hit,
  output logic     [NUM_SRC-1:0]   o_id_busy,
  output logic                     o_full,
  output logic                     o_no_room
);
  localparam int  IDX_W        = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int  CW           = $clog2(SB_DEPTH + 2);
  localparam bit  PEND_IS_BUSY = (MC_LAT >= 3);

  sb_entry_t             r_sb     [SB_DEPTH];
  sb_entry_t             w_sb_nxt [SB_DEPTH];
  logic                  w_free_found;
  logic [IDX_W-1:0]      w_free_idx;
  logic [CW-1:0]         w_nvalid;
  logic [SB_DEPTH-1:0]   w_valid;

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_nvalid     = '0;
    for (int e = SB_DEPTH-1; e >= 0; e--) begin
      w_valid[e] = r_sb[e].valid;
      w_nvalid   = w_nvalid + CW'(r_sb[e].valid);
      if (!r_sb[e].valid) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(e);
      end
    end
  end

  // Free slot is chosen from the pre-edge state, so a slot retiring at this
  // edge is not reused until the next one.
  always_comb begin
    for (int e = 0; e < SB_DEPTH; e++) w_sb_nxt[e] = r_sb[e];
    if (i_pipe_en) begin
      for (int e = 0; e < SB_DEPTH; e++) begin
        if (r_sb[e].valid) begin
          if (r_sb[e].cnt == SB_CNT_W'(1) || (i_ex_wr && r_sb[e].rd == i_ex_rd))
            w_sb_nxt[e] = '0;
          else
            w_sb_nxt[e].cnt = r_sb[e].cnt - SB_CNT_W'(1);
        end
      end
      if (i_ex_alloc_req && w_free_found) begin
        w_sb_nxt[w_free_idx].valid = 1'b1;
        w_sb_nxt[w_free_idx].rd    = i_ex_rd;
        w_sb_nxt[w_free_idx].cnt   = SB_CNT_W'(MC_LAT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < SB_DEPTH; e++) r_sb[e] <= '0;
    end else begin
      r_sb <= w_sb_nxt;
    end
  end

  // Entries never hold x0, so source x0 can never match.
  always_comb begin
    o_ex_mc_hit = '0;
    o_id_busy   = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int e = 0; e < SB_DEPTH; e++) begin
        if (r_sb[e].valid && r_sb[e].rd == i_ex_rs[s] && r_sb[e].cnt == SB_CNT_W'(1))
          o_ex_mc_hit[s] = 1'b1;
        if (r_sb[e].valid && r_sb[e].rd == i_id_rs[s] && r_sb[e].cnt >= SB_CNT_W'(3))
          o_id_busy[s] = 1'b1;
      end
      if (PEND_IS_BUSY && i_ex_alloc_req && i_ex_rd == i_id_rs[s])
        o_id_busy[s] = 1'b1;
    end
  end

  assign o_full    = &w_valid;
  assign o_no_room = (w_nvalid + CW'(i_ex_alloc_req)) >= CW'(SB_DEPTH);
endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and ID stall generation for the RV32I pipeline.
// Optional perf counters are built only when FWD_HAZARD_PERF_EN is defined.
module fwd_hazard_unit
  import fwd_hazard_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = 2,
  parameter int SB_DEPTH = 2,
  parameter int MC_LAT   = 4,
  parameter int CNT_W    = 32,
  parameter int SEL_W    = $clog2(NUM_FWD + 2)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_pipe_en,
  input  logic                            i_id_valid,
  input  logic                            i_id_is_mc,
  input  logic [NUM_SRC-1:0][REG_W-1:0]   i_id_rs_s,
  input  logic [NUM_SRC-1:0]              i_id_rs_used,
  input  logic                            i_ex_valid,
  input  logic                            i_ex_regf_we,
  input  logic                            i_ex_is_load,
  input  logic                            i_ex_is_mc,
  input  logic [REG_W-1:0]                i_ex_rd_s,
  input  logic [NUM_SRC-1:0][REG_W-1:0]   i_ex_rs_s,
  input  logic [NUM_FWD-1:0]              i_stg_valid,
  input  logic [NUM_FWD-1:0]              i_stg_regf_we,
  input  logic [NUM_FWD-1:0][REG_W-1:0]   i_stg_rd_s,
  output logic [NUM_SRC-1:0][SEL_W-1:0]   o_fwd_sel,
  output logic                            o_stall_id,
  output logic                            o_sb_full,
  output logic [CNT_W-1:0]                o_lu_stall_cnt,
  output logic [CNT_W-1:0]                o_mc_stall_cnt
);
  logic                          w_ex_wr;
  logic                          w_alloc_req;
  logic [NUM_SRC-1:0]            w_ex_mc_hit;
  logic [NUM_SRC-1:0]            w_id_busy;
  logic                          w_no_room;
  logic [NUM_SRC-1:0][SEL_W-1:0] w_sel;
  logic                          w_lu_hit;
  logic                          w_mc_hit;
  logic                          w_full_stall;

  assign w_ex_wr     = i_ex_valid & i_ex_regf_we;
  assign w_alloc_req = w_ex_wr & i_ex_is_mc & (i_ex_rd_s != '0);

  fwd_scoreboard #(
    .NUM_SRC  (NUM_SRC),
    .SB_DEPTH (SB_DEPTH),
    .MC_LAT   (MC_LAT)
  ) u_sb (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pipe_en      (i_pipe_en),
    .i_ex_wr        (w_ex_wr),
    .i_ex_alloc_req (w_alloc_req),
    .i_ex_rd        (i_ex_rd_s),
    .i_ex_rs        (i_ex_rs_s),
    .i_id_rs        (i_id_rs_s),
    .o_ex_mc_hit    (w_ex_mc_hit),
    .o_id_busy      (w_id_busy),
    .o_full         (o_sb_full),
    .o_no_room      (w_no_room)
  );

  // Oldest stage is applied first so younger stages overwrite it; the
  // retiring MC result wins over everything.
  always_comb begin
    w_sel = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      w_sel[s] = SEL_W'(FWD_SEL_RF);
      for (int j = NUM_FWD-1; j >= 0; j--) begin
        if (i_stg_valid[j] && i_stg_regf_we[j] && i_ex_rs_s[s] != '0 &&
            i_stg_rd_s[j] == i_ex_rs_s[s])
          w_sel[s] = SEL_W'(j + 1);
      end
      if (w_ex_mc_hit[s]) w_sel[s] = SEL_W'(fwd_sel_mc(NUM_FWD));
    end
  end

  always_comb begin
    w_lu_hit = 1'b0;
    w_mc_hit = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (i_id_rs_used[s] && i_id_rs_s[s] != '0) begin
        if (w_ex_wr && i_ex_is_load && i_id_rs_s[s] == i_ex_rd_s) w_lu_hit = 1'b1;
        if (w_id_busy[s]) w_mc_hit = 1'b1;
      end
    end
  end

  assign w_full_stall = i_id_is_mc & w_no_room;
  assign o_fwd_sel    = rst_n ? w_sel : '0;
  assign o_stall_id   = rst_n & i_id_valid & (w_lu_hit | w_mc_hit | w_full_stall);

`ifdef FWD_HAZARD_PERF_EN
  logic             w_lu_act;
  logic             w_mc_act;
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_mc_cnt;

  assign w_lu_act = i_id_valid & w_lu_hit;
  assign w_mc_act = i_id_valid & (w_mc_hit | w_full_stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_cnt <= '0;
      r_mc_cnt <= '0;
    end else begin
      if (w_lu_act && !(&r_lu_cnt)) r_lu_cnt <= r_lu_cnt + CNT_W'(1);
      if (w_mc_act && !(&r_mc_cnt)) r_mc_cnt <= r_mc_cnt + CNT_W'(1);
    end
  end

  assign o_lu_stall_cnt = r_lu_cnt;
  assign o_mc_stall_cnt = r_mc_cnt;
`else
  assign o_lu_stall_cnt = '0;
  assign o_mc_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: vector table, directed multi-cycle sequences and
// randomized traffic against a queue-based model of the in-flight MC ops.
module tb_fwd_hazard_unit;
  localparam int NUM_SRC  = 2;
  localparam int NUM_FWD  = 2;
  localparam int SB_DEPTH = 2;
  localparam int MC_LAT   = 4;
  localparam int CNT_W    = 32;
  localparam int SEL_W    = $clog2(NUM_FWD + 2);
  localparam int SEL_MC   = NUM_FWD + 1;
`ifdef FWD_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pipe_en, id_valid, id_is_mc, ex_valid, ex_regf_we, ex_is_load, ex_is_mc;
  logic [NUM_SRC-1:0][4:0] id_rs_s, ex_rs_s;
  logic [NUM_SRC-1:0]      id_rs_used;
  logic [4:0]              ex_rd_s;
  logic [NUM_FWD-1:0]      stg_valid, stg_regf_we;
  logic [NUM_FWD-1:0][4:0] stg_rd_s;
  logic [NUM_SRC-1:0][SEL_W-1:0] fwd_sel;
  logic stall_id, sb_full;
  logic [CNT_W-1:0] lu_cnt, mc_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .SB_DEPTH(SB_DEPTH),
    .MC_LAT(MC_LAT), .CNT_W(CNT_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_pipe_en(pipe_en),
    .i_id_valid(id_valid), .i_id_is_mc(id_is_mc),
    .i_id_rs_s(id_rs_s), .i_id_rs_used(id_rs_used),
    .i_ex_valid(ex_valid), .i_ex_regf_we(ex_regf_we), .i_ex_is_load(ex_is_load),
    .i_ex_is_mc(ex_is_mc), .i_ex_rd_s(ex_rd_s), .i_ex_rs_s(ex_rs_s),
    .i_stg_valid(stg_valid), .i_stg_regf_we(stg_regf_we), .i_stg_rd_s(stg_rd_s),
    .o_fwd_sel(fwd_sel), .o_stall_id(stall_id), .o_sb_full(sb_full),
    .o_lu_stall_cnt(lu_cnt), .o_mc_stall_cnt(mc_cnt)
  );

  // Reference model: a bag of in-flight MC ops, each with cycles remaining.
  typedef struct { int rd; int rem; } mop_t;
  mop_t   mq[$];
  longint m_lu = 0;
  longint m_mc = 0;

  function automatic bit m_pend();
    return ex_valid && ex_is_mc && ex_regf_we && ex_rd_s != 0;
  endfunction

  function automatic bit m_lu_now();
    bit r = 0;
    for (int k = 0; k < NUM_SRC; k++)
      if (id_rs_used[k] && id_rs_s[k] != 0 && id_rs_s[k] == ex_rd_s &&
          ex_valid && ex_is_load && ex_regf_we) r = 1;
    return r;
  endfunction

  function automatic bit m_mc_now();
    bit r = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_rs_used[k] && id_rs_s[k] != 0) begin
        foreach (mq[i]) if (mq[i].rd == int'(id_rs_s[k]) && mq[i].rem >= 3) r = 1;
        if (m_pend() && ex_rd_s == id_rs_s[k] && MC_LAT >= 3) r = 1;
      end
    end
    return r;
  endfunction

  function automatic bit m_full_now();
    return id_is_mc && (mq.size() + int'(m_pend()) >= SB_DEPTH);
  endfunction

  function automatic bit m_stall();
    return rst_n && id_valid && (m_lu_now() || m_mc_now() || m_full_now());
  endfunction

  function automatic int m_sel(int k);
    int r = 0;
    if (!rst_n || ex_rs_s[k] == 0) return 0;
    for (int j = NUM_FWD-1; j >= 0; j--)
      if (stg_valid[j] && stg_regf_we[j] && stg_rd_s[j] == ex_rs_s[k]) r = j + 1;
    foreach (mq[i]) if (mq[i].rem == 1 && mq[i].rd == int'(ex_rs_s[k])) r = SEL_MC;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    mop_t nq[$];
    int   n0;
    if (!rst_n) begin
      mq.delete();
      m_lu = 0;
      m_mc = 0;
    end else begin
      if (id_valid && m_lu_now() && m_lu < 64'hFFFF_FFFF) m_lu++;
      if (id_valid && (m_mc_now() || m_full_now()) && m_mc < 64'hFFFF_FFFF) m_mc++;
      if (pipe_en) begin
        n0 = mq.size();
        nq.delete();
        foreach (mq[i]) begin
          if (mq[i].rem != 1 && !(ex_valid && ex_regf_we && mq[i].rd == int'(ex_rd_s)))
            nq.push_back('{mq[i].rd, mq[i].rem - 1});
        end
        if (m_pend() && n0 < SB_DEPTH) nq.push_back('{int'(ex_rd_s), MC_LAT});
        mq = nq;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NUM_SRC; k++) chk($sformatf("fwd_sel[%0d]", k), fwd_sel[k], m_sel(k));
    chk("stall_id", stall_id, m_stall());
    chk("sb_full", sb_full, rst_n && mq.size() == SB_DEPTH);
    chk("lu_stall_cnt", lu_cnt, PERF ? m_lu : 0);
    chk("mc_stall_cnt", mc_cnt, PERF ? m_mc : 0);
  endtask

  task automatic idle();
    pipe_en = 1; id_valid = 0; id_is_mc = 0; id_rs_s = '0; id_rs_used = '0;
    ex_valid = 0; ex_regf_we = 0; ex_is_load = 0; ex_is_mc = 0; ex_rd_s = '0;
    ex_rs_s = '0; stg_valid = '0; stg_regf_we = '0; stg_rd_s = '0;
  endtask

  task automatic cyc();
    #1 check_all();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ex_mc(input int rd);
    ex_valid = 1; ex_regf_we = 1; ex_is_mc = 1; ex_rd_s = 5'(rd);
  endtask

  task automatic drain();
    idle();
    repeat (MC_LAT + 2) cyc();
  endtask

  typedef struct {
    bit idv; int ers0; int ers1; bit [1:0] sv; bit [1:0] sw; int srd1; int srd2;
    int irs0; int irs1; bit [1:0] iu; bit ev; bit ew; bit el; int erd;
    int es0; int es1; bit est;
  } vec_t;
  vec_t tv[12];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_st;
    longint lu0;
    logic st;
    int exp_st[6] = '{0, 1, 1, 1, 1, 0};
    int exp_f [6] = '{0, 0, 1, 1, 1, 0};

    tv[0]  = '{0, 5,0, 2'b11,2'b11, 5,5, 0,0, 2'b00, 0,0,0, 0, 1,0, 0};
    tv[1]  = '{0, 5,0, 2'b11,2'b11, 6,5, 0,0, 2'b00, 0,0,0, 0, 2,0, 0};
    tv[2]  = '{0, 0,5, 2'b11,2'b10, 5,5, 0,0, 2'b00, 0,0,0, 0, 0,2, 0};
    tv[3]  = '{0, 0,0, 2'b11,2'b11, 0,0, 0,0, 2'b00, 0,0,0, 0, 0,0, 0};
    tv[4]  = '{0, 5,5, 2'b00,2'b11, 5,5, 0,0, 2'b00, 0,0,0, 0, 0,0, 0};
    tv[5]  = '{1, 0,0, 2'b00,2'b00, 0,0, 0,7, 2'b10, 1,1,1, 7, 0,0, 1};
    tv[6]  = '{1, 0,0, 2'b00,2'b00, 0,0, 0,7, 2'b01, 1,1,1, 7, 0,0, 0};
    tv[7]  = '{1, 0,0, 2'b00,2'b00, 0,0, 0,7, 2'b10, 1,1,0, 7, 0,0, 0};
    tv[8]  = '{1, 0,0, 2'b00,2'b00, 0,0, 0,0, 2'b11, 1,1,1, 0, 0,0, 0};
    tv[9]  = '{1, 0,0, 2'b00,2'b00, 0,0, 7,0, 2'b01, 1,0,1, 7, 0,0, 0};
    tv[10] = '{0, 3,4, 2'b11,2'b11, 4,3, 0,0, 2'b00, 0,0,0, 0, 2,1, 0};
    tv[11] = '{0, 0,0, 2'b00,2'b00, 0,0, 7,0, 2'b01, 1,1,1, 7, 0,0, 0};

    // Reset state
    idle();
    #12;
    chk("rst_stall", stall_id, 0);
    chk("rst_full", sb_full, 0);
    chk("rst_sel", fwd_sel, 0);
    check_all();
    @(negedge clk);
    rst_n = 1;

    // Combinational forwarding / load-use table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      idle();
      id_valid = tv[i].idv;
      ex_rs_s[0] = 5'(tv[i].ers0); ex_rs_s[1] = 5'(tv[i].ers1);
      stg_valid = tv[i].sv; stg_regf_we = tv[i].sw;
      stg_rd_s[0] = 5'(tv[i].srd1); stg_rd_s[1] = 5'(tv[i].srd2);
      id_rs_s[0] = 5'(tv[i].irs0); id_rs_s[1] = 5'(tv[i].irs1); id_rs_used = tv[i].iu;
      ex_valid = tv[i].ev; ex_regf_we = tv[i].ew; ex_is_load = tv[i].el;
      ex_rd_s = 5'(tv[i].erd);
      #1;
      chk($sformatf("vec%0d_sel0", i), fwd_sel[0], tv[i].es0);
      chk($sformatf("vec%0d_sel1", i), fwd_sel[1], tv[i].es1);
      chk($sformatf("vec%0d_stall", i), stall_id, tv[i].est);
    end
    @(negedge clk);
    drain();

    // Load-use: one stall cycle, then forwarded from EX/MEM
    lu0 = longint'(lu_cnt);
    ex_valid = 1; ex_regf_we = 1; ex_is_load = 1; ex_rd_s = 7;
    id_valid = 1; id_rs_s[1] = 7; id_rs_used = 2'b10;
    #1 chk("lu_stall", stall_id, 1);
    cyc();
    idle();
    ex_valid = 1; ex_rs_s[1] = 7;
    stg_valid[0] = 1; stg_regf_we[0] = 1; stg_rd_s[0] = 7;
    #1;
    chk("lu_fwd_sel1", fwd_sel[1], 1);
    chk("lu_no_stall", stall_id, 0);
    chk("lu_cnt_delta", longint'(lu_cnt) - lu0, PERF ? 1 : 0);
    cyc();
    drain();

    // MC dependency: plain and with a 3-cycle freeze mid-flight
    for (int frz = 0; frz < 2; frz++) begin
      ex_mc(3); id_valid = 1; id_rs_s[0] = 9; id_rs_used = 2'b01;
      cyc();
      idle();
      id_valid = 1; id_rs_s[1] = 3; id_rs_used = 2'b10;
      n_st = 0;
      for (int c = 0; c < 20; c++) begin
        pipe_en = (frz != 0 && c >= 1 && c <= 3) ? 1'b0 : 1'b1;
        #1 st = stall_id;
        check_all();
        @(posedge clk);
        @(negedge clk);
        if (!st) break;
        n_st++;
      end
      chk($sformatf("mc_stall_cycles_frz%0d", frz), n_st, frz ? 5 : 2);
      idle();
      ex_valid = 1; ex_rs_s[1] = 3;
      #1 chk("mc_fwd_sel", fwd_sel[1], SEL_MC);
      cyc();
      ex_valid = 1; ex_rs_s[1] = 3;
      #1 chk("mc_freed_sel", fwd_sel[1], 0);
      cyc();
      drain();
    end

    // Scoreboard full: third MC waits until the oldest entry retires
    for (int c = 0; c < 6; c++) begin
      idle();
      id_valid = 1; id_is_mc = 1;
      if (c == 0) ex_mc(1);
      if (c == 1) ex_mc(2);
      #1;
      chk($sformatf("full_c%0d_stall", c), stall_id, exp_st[c]);
      chk($sformatf("full_c%0d_sbfull", c), sb_full, exp_f[c]);
      cyc();
    end
    drain();

    // WAW: ALU write to x4 kills the pending MC entry
    ex_mc(4);
    cyc();
    idle();
    ex_valid = 1; ex_regf_we = 1; ex_rd_s = 4;
    id_valid = 1; id_rs_s[0] = 4; id_rs_used = 2'b01;
    cyc();
    for (int c = 0; c < 5; c++) begin
      idle();
      ex_valid = 1; ex_rs_s[0] = 4;
      id_valid = 1; id_rs_s[0] = 4; id_rs_used = 2'b01;
      #1;
      chk($sformatf("waw_sel_c%0d", c), fwd_sel[0], 0);
      chk($sformatf("waw_stall_c%0d", c), stall_id, 0);
      cyc();
    end
    drain();

    // Async reset with two live entries
    ex_mc(8); cyc();
    idle(); ex_mc(9); cyc();
    idle(); cyc(); cyc();
    ex_valid = 1; ex_rs_s[0] = 8; ex_rs_s[1] = 5;
    stg_valid[0] = 1; stg_regf_we[0] = 1; stg_rd_s[0] = 5;
    id_valid = 1; id_is_mc = 1;
    #1;
    chk("prerst_sel0", fwd_sel[0], SEL_MC);
    chk("prerst_sel1", fwd_sel[1], 1);
    chk("prerst_stall", stall_id, 1);
    chk("prerst_full", sb_full, 1);
    #1 rst_n = 0;
    #1;
    chk("rst_mid_sel", fwd_sel, 0);
    chk("rst_mid_stall", stall_id, 0);
    chk("rst_mid_full", sb_full, 0);
    check_all();
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("postrst_sel0", fwd_sel[0], 0);
    chk("postrst_stall", stall_id, 0);
    chk("postrst_full", sb_full, 0);
    @(negedge clk);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      pipe_en    = ($urandom_range(0, 9) < 8);
      id_valid   = 1'($urandom_range(0, 1));
      id_is_mc   = ($urandom_range(0, 3) == 0);
      id_rs_used = NUM_SRC'($urandom);
      ex_valid   = 1'($urandom_range(0, 1));
      ex_regf_we = ($urandom_range(0, 3) != 0);
      ex_is_load = ($urandom_range(0, 3) == 0);
      ex_is_mc   = ($urandom_range(0, 2) == 0);
      ex_rd_s    = 5'($urandom_range(0, 7));
      for (int k = 0; k < NUM_SRC; k++) begin
        id_rs_s[k] = 5'($urandom_range(0, 7));
        ex_rs_s[k] = 5'($urandom_range(0, 7));
      end
      stg_valid   = NUM_FWD'($urandom);
      stg_regf_we = NUM_FWD'($urandom);
      for (int j = 0; j < NUM_FWD; j++) stg_rd_s[j] = 5'($urandom_range(0, 7));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard controller for the pipelined RV32I core. It generalises operand bypassing to NUM_SRC source operands and NUM_FWD writeback stages, detects load-use hazards, and tracks in-flight fixed-latency multi-cycle (MC) operations in a scoreboard. It sits beside ID/EX: it drives operand-mux selects into EX and a stall to IF/ID.

## Interface
- NUM_SRC, 2: source operands per instruction (2 or 3).
- NUM_FWD, 2: forwarding stages; stage 1 = EX/MEM (youngest) … stage NUM_FWD = oldest.
- SB_DEPTH, 2: scoreboard entries (outstanding MC ops).
- MC_LAT, 4: MC latency in advancing cycles, ≥2.
- CNT_W, 32: perf counter width.
- SEL_W: derived, $clog2(NUM_FWD+2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- pipe_en  in  1  pipeline advances this cycle.
- id_valid, id_is_mc  in  1 each  ID instruction valid / is MC op.
- id_rs_s  in  NUM_SRC*5  ID sources; id_rs_used  in  NUM_SRC  per-source use.
- ex_valid, ex_regf_we, ex_is_load, ex_is_mc  in  1 each  EX instruction attributes.
- ex_rd_s  in  5;  ex_rs_s  in  NUM_SRC*5  EX destination/sources.
- stg_valid, stg_regf_we  in  NUM_FWD each;  stg_rd_s  in  NUM_FWD*5.
- fwd_sel  out  NUM_SRC*SEL_W  per EX source: 0 = regfile, k = stage k, NUM_FWD+1 = MC result.
- stall_id  out  1  hold PC and IF/ID, inject bubble into ID/EX.
- sb_full  out  1  all entries valid.
- lu_stall_cnt, mc_stall_cnt  out  CNT_W each  perf counters.

## Operation
- Source hit: register x0 never hits; a hit needs producer valid & regf_we & rd_s match.
- fwd_sel priority: MC entry with cnt==1 > stage 1 > … > stage NUM_FWD > regfile (0).
- Scoreboard entry {valid, rd, cnt}. Allocate when ex_valid & ex_is_mc & ex_regf_we & ex_rd_s≠0 & pipe_en: lowest-index free entry, cnt=MC_LAT.
- When pipe_en=1: valid entries decrement cnt; an entry at cnt==1 frees (valid→0) at that edge. When pipe_en=0: all cnt frozen.
- WAW: on any EX write leaving EX (pipe_en, ex_valid, ex_regf_we) to rd matching a valid entry, that entry is invalidated at the same edge. A simultaneous new MC allocation to that rd occupies a new entry.
- Load-use stall: ID used source equals ex_rd_s with ex_valid & ex_is_load & ex_regf_we.
- MC stall: ID used source matches a valid entry with cnt≥3, or ex_is_mc alloc pending to that rd with MC_LAT≥3.
- Full stall: id_valid & id_is_mc & (valid entries + pending EX alloc ≥ SB_DEPTH).
- stall_id = id_valid & (load-use | MC | full).
- Reset: all entries invalid, cnt=0; counters 0; outputs fwd_sel=0, stall_id=0, sb_full=0.

## Timing
- fwd_sel, stall_id, and sb_full are combinational from inputs and scoreboard state, with 0-cycle latency.
- Scoreboard and counters update on the rising clk edge. rst_n clears them immediately, regardless of the clock, mid-operation included.
- MC result is forwardable exactly in the advancing cycle where cnt==1. Once freed, it is read from the regfile.
- Alloc and free of different entries in the same edge are both honoured. When full, a free at this edge does not unblock the stall until the next cycle.

## Configuration
- FWD_HAZARD_PERF_EN defined: lu_stall_cnt increments each cycle the load-use stall is active. mc_stall_cnt increments each cycle the MC or full stall is active. Both saturate at all-ones.
- FWD_HAZARD_PERF_EN undefined: the counter logic is absent and both ports are tied to 0.

## Structure
- Package fwd_hazard_pkg holds:
  - the constants FWD_SEL_RF=0 and the MC select encoding (NUM_FWD+1) helper;
  - the sb_entry_t struct;
  - the reg index type.
- Sub-module fwd_scoreboard owns the entries, allocation, countdown, WAW invalidation, and match/full queries. The top module handles the priority mux, stall, and counters.

## Test plan
- EX/MEM writes x5, EX reads rs1=x5, MEM/WB also writes x5 -> fwd_sel[0]=1.
- Load to x7 in EX, ID uses rs2=x7 -> stall_id=1 for 1 cycle. Next cycle EX rs2 sel=1, lu_stall_cnt=1.
- MC to x3 (MC_LAT=4), dependent follows -> 2 stall cycles, then EX sel=NUM_FWD+1 at cnt==1. With pipe_en=0 for 3 cycles mid-flight, the stall extends by 3.
- SB_DEPTH=2: two MC ops in flight, third MC in ID -> stall_id=1, sb_full=1 until the first entry frees.
- MC to x4, then an ALU write to x4 leaves EX -> entry invalidated. A later x4 reader never selects MC.
- Assert rst_n with 2 entries valid -> entries are cleared immediately, stall_id=0, fwd_sel=0.
